// File: rtl/serial_shifter.sv
// serial_shifter: iterative SLL/SRL/SRA/ROTR unit, one bit position per clock, start/busy/done handshake.
module serial_shifter #(
  parameter int word_size = 32,
  parameter int sa_size   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           shift_op,
  input  logic [word_size-1:0] shift_amount,
  input  logic [word_size-1:0] input_data,
  output logic [word_size-1:0] output_data,
  output logic                 busy,
  output logic                 done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  logic [1:0]           state_q, state_d;
  logic [sa_size-1:0]   count_q, count_d;
  logic [1:0]           op_q, op_d;
  logic [word_size-1:0] data_q, data_d, step;
  logic                 accept;
  // SRA and ROTR differ only in the bit entering at the top.
  assign step = op_q == OP_SLL ? {data_q[word_size-2:0], 1'b0}
              : op_q == OP_SRL ? {1'b0, data_q[word_size-1:1]}
              : {op_q[0] ? data_q[0] : data_q[word_size-1], data_q[word_size-1:1]};
  assign accept = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    data_d  = data_q;
    if (accept) begin
      state_d = SHIFT;
      count_d = shift_amount[sa_size-1:0];
      op_d    = shift_op;
      data_d  = input_data;
    end else if (state_q == SHIFT) begin
      state_d = count_q == '0 ? DONE : SHIFT;
      count_d = count_q == '0 ? count_q : count_q - 1'b1;
      data_d  = count_q == '0 ? data_q : step;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= OP_SLL;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end
  assign output_data = data_q;
  assign busy        = state_q == SHIFT;
  assign done        = state_q == DONE;
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed table of shift vectors plus reset-abort and back-to-back sequences.
module tb_serial_shifter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  shift_op = 2'd0;
  logic [31:0] shift_amount = '0;
  logic [31:0] input_data = '0;
  logic [31:0] output_data;
  logic        busy, done;
  int n_tests = 0;
  int n_fail  = 0;

  serial_shifter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_op(shift_op),
    .shift_amount(shift_amount), .input_data(input_data),
    .output_data(output_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] amt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, nb, n;
    logic [31:0] res;
    n = int'(v.amt[4:0]);
    @(negedge clk);
    shift_op = v.op; shift_amount = v.amt; input_data = v.data; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; input_data = ~v.data; shift_op = ~v.op; shift_amount = 32'h1f;
    lat = 1; nb = 0;
    while (!done && lat < 100) begin
      nb += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), lat, n + 2);
    check($sformatf("vec%0d busy_cycles", idx), nb, n + 1);
    check($sformatf("vec%0d result", idx), output_data, v.exp);
    check($sformatf("vec%0d busy_in_done", idx), {31'd0, busy}, 32'd0);
    res = output_data;
    @(posedge clk); #1;
    check($sformatf("vec%0d done_pulse", idx), {31'd0, done}, 32'd0);
    check($sformatf("vec%0d hold", idx), output_data, res);
  endtask

  initial begin
    vec_t vecs[12];
    int seen, lat;
    vecs[0]  = '{2'd0, 32'd31,        32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{2'd2, 32'd4,         32'h8000_00F0, 32'hF800_000F};
    vecs[2]  = '{2'd1, 32'd4,         32'h8000_00F0, 32'h0800_000F};
    vecs[3]  = '{2'd3, 32'd8,         32'h1234_5678, 32'h7812_3456};
    vecs[4]  = '{2'd3, 32'd0,         32'h1234_5678, 32'h1234_5678};
    vecs[5]  = '{2'd0, 32'h0000_0023, 32'h0000_0001, 32'h0000_0008};
    vecs[6]  = '{2'd2, 32'd31,        32'h8000_0000, 32'hFFFF_FFFF};
    vecs[7]  = '{2'd3, 32'd31,        32'h8000_0001, 32'h0000_0003};
    vecs[8]  = '{2'd1, 32'd31,        32'hFFFF_FFFF, 32'h0000_0001};
    vecs[9]  = '{2'd0, 32'd1,         32'hA5A5_A5A5, 32'h4B4B_4B4A};
    vecs[10] = '{2'd2, 32'd4,         32'h7FFF_FFF0, 32'h07FF_FFFF};
    vecs[11] = '{2'd3, 32'd1,         32'h0000_0001, 32'h8000_0000};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset output_data", output_data, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Abort a long SLL midway with an asynchronous reset.
    @(negedge clk);
    shift_op = 2'd0; shift_amount = 32'd20; input_data = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort output_data", output_data, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      seen += int'(done) + int'(busy);
    end
    check("abort no activity", seen, 0);
    run_vec(12, vecs[3]);

    // Back-to-back: ignored start during SHIFT, then start accepted in the DONE cycle.
    @(negedge clk);
    shift_op = 2'd0; shift_amount = 32'd3; input_data = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    shift_op = 2'd1; shift_amount = 32'd1; input_data = 32'hFFFF_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first done", {31'd0, done}, 32'd1);
    check("b2b first result", output_data, 32'h0000_0008);
    shift_op = 2'd3; shift_amount = 32'd8; input_data = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; input_data = '0;
    check("b2b accepted busy", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b done spacing", lat, 10);
    check("b2b second result", output_data, 32'h7812_3456);
    @(posedge clk); #1;
    check("b2b final idle", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
